tcas_reply_pulse_det: RTL and testbench

//  Pulse detector for the TCAS receive chain, clk_20 domain. Sits directly after the beamformer/bearing stage.

---
 rtl/tcas_reply_pulse_det.sv | 210 +++++++++++++++++++++
 tb/tb_tcas_reply_pulse_det.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcas_reply_pulse_det.sv
// TCAS receive-chain pulse detector (clk_20 domain): qualifies MAIN samples against threshold and
// sidelobe margin, measures each legal-width pulse and queues a report for the reply decoder.
module tcas_reply_pulse_det #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_W      = 6,
  parameter int MAX_W      = 30,
  parameter int DATA_W     = 16
) (
  input  logic                  clk_20,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_W-1:0]     thr,
  input  logic [DATA_W-1:0]     sls_margin,
  input  logic [DATA_W-1:0]     ampl_main,
  input  logic [DATA_W-1:0]     ampl_omega,
  input  logic [DATA_W-1:0]     ampl_omni,
  input  logic [8:0]            bearing,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [2*DATA_W+48:0]  rpt_data,
  output logic [7:0]            ovf_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RPT_W = 2*DATA_W + 49;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PULSE   = 2'd1;
  localparam logic [1:0] S_TOOLONG = 2'd2;

  localparam logic [7:0]       MIN_W8  = 8'(MIN_W);
  localparam logic [7:0]       MAX_W8  = 8'(MAX_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage p0: input registers and time stamp ----
  logic [DATA_W-1:0] main_p0_q, main_p0_d, omega_p0_q, omega_p0_d, omni_p0_q, omni_p0_d;
  logic [DATA_W-1:0] thr_p0_q, thr_p0_d, sls_p0_q, sls_p0_d;
  logic [8:0]        brg_p0_q, brg_p0_d;
  logic [23:0]       ts_p0_q, ts_p0_d, tstamp_q, tstamp_d;
  logic              hit_p0;

  always_comb begin
    main_p0_d  = ampl_main;
    omega_p0_d = ampl_omega;
    omni_p0_d  = ampl_omni;
    thr_p0_d   = thr;
    sls_p0_d   = sls_margin;
    brg_p0_d   = bearing;
    ts_p0_d    = tstamp_q;
    tstamp_d   = tstamp_q + 24'd1;
  end

  always_ff @(posedge clk_20 or posedge reset) begin
    if (reset) begin
      main_p0_q  <= '0;
      omega_p0_q <= '0;
      omni_p0_q  <= '0;
      thr_p0_q   <= '0;
      sls_p0_q   <= '0;
      brg_p0_q   <= '0;
      ts_p0_q    <= '0;
      tstamp_q   <= '0;
    end else begin
      main_p0_q  <= main_p0_d;
      omega_p0_q <= omega_p0_d;
      omni_p0_q  <= omni_p0_d;
      thr_p0_q   <= thr_p0_d;
      sls_p0_q   <= sls_p0_d;
      brg_p0_q   <= brg_p0_d;
      ts_p0_q    <= ts_p0_d;
      tstamp_q   <= tstamp_d;
    end
  end

  // Sidelobe test is one bit wider than the data so a large margin cannot wrap into a pass.
  always_comb begin
    hit_p0 = (main_p0_q >= thr_p0_q) &&
             ({1'b0, main_p0_q} >= ({1'b0, omega_p0_q} + {1'b0, sls_p0_q}));
  end

  // ---- stage p1: pulse measurement FSM and report register ----
  logic [1:0]        state_q, state_d;
  logic [7:0]        width_q, width_d;
  logic [DATA_W-1:0] peak_q, peak_d, pomni_q, pomni_d;
  logic [8:0]        pbrg_q, pbrg_d;
  logic [23:0]       t0_q, t0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [RPT_W-1:0]  rpt_p1_q, rpt_p1_d;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    peak_d   = peak_q;
    pomni_d  = pomni_q;
    pbrg_d   = pbrg_q;
    t0_d     = t0_q;
    vld_p1_d = 1'b0;
    rpt_p1_d = {t0_q, width_q, peak_q, pomni_q, pbrg_q, 8'h00};
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit_p0) begin
            state_d = S_PULSE;
            width_d = 8'd1;
            peak_d  = main_p0_q;
            pomni_d = omni_p0_q;
            pbrg_d  = brg_p0_q;
            t0_d    = ts_p0_q;
          end
        end
        S_PULSE: begin
          if (hit_p0) begin
            if (width_q == MAX_W8) begin
              state_d = S_TOOLONG;
            end else begin
              width_d = width_q + 8'd1;
              // Strict compare: on equal peaks the earliest sample wins.
              if (main_p0_q > peak_q) begin
                peak_d  = main_p0_q;
                pomni_d = omni_p0_q;
                pbrg_d  = brg_p0_q;
              end
            end
          end else begin
            state_d  = S_IDLE;
            vld_p1_d = (width_q >= MIN_W8);
          end
        end
        S_TOOLONG: begin
          if (!hit_p0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_20 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk_20) begin
    peak_q   <= peak_d;
    pomni_q  <= pomni_d;
    pbrg_q   <= pbrg_d;
    t0_q     <= t0_d;
    rpt_p1_q <= rpt_p1_d;
  end

  // ---- stage p2: report FIFO with registered show-ahead head ----
  logic [RPT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_left;
  logic [7:0]       ovf_q, ovf_d;
  logic [RPT_W-1:0] rdata_q, rdata_d;
  logic             pop, accept;

  always_comb begin
    pop      = (cnt_q != '0) && rpt_ready;
    accept   = vld_p1_q && ((cnt_q != DEPTH_C) || pop);
    cnt_left = cnt_q - CNT_W'(pop);
    cnt_d    = cnt_left + CNT_W'(accept);
    rd_d     = rd_q + PTR_W'(pop);
    wr_d     = wr_q + PTR_W'(accept);
    ovf_d    = (vld_p1_q && !accept) ? sat_inc8(ovf_q) : ovf_q;
    rdata_d  = rdata_q;
    // When nothing older remains, the entry being written becomes the head directly.
    if (cnt_left != '0)  rdata_d = mem_q[rd_d];
    else if (accept)     rdata_d = rpt_p1_q;
  end

  always_ff @(posedge clk_20 or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_20) begin
    if (accept) mem_q[wr_q] <= rpt_p1_q;
  end

  assign rpt_valid = (cnt_q != '0);
  assign rpt_data  = rdata_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_tcas_reply_pulse_det.sv
// Bench for tcas_reply_pulse_det: directed scenarios with literal expectations plus a randomized
// phase, all compared every cycle against a run-length behavioural model.
module tb_tcas_reply_pulse_det;
  localparam int FIFO_DEPTH = 4;
  localparam int MIN_W      = 6;
  localparam int MAX_W      = 30;

  logic        clk_20 = 1'b0;
  logic        reset, enable, rpt_ready, rpt_valid;
  logic [15:0] thr, sls_margin, ampl_main, ampl_omega, ampl_omni;
  logic [8:0]  bearing;
  logic [80:0] rpt_data;
  logic [7:0]  ovf_cnt;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  tcas_reply_pulse_det #(
    .FIFO_DEPTH(FIFO_DEPTH), .MIN_W(MIN_W), .MAX_W(MAX_W), .DATA_W(16)
  ) dut (
    .clk_20(clk_20), .reset(reset), .enable(enable), .thr(thr), .sls_margin(sls_margin),
    .ampl_main(ampl_main), .ampl_omega(ampl_omega), .ampl_omni(ampl_omni), .bearing(bearing),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data), .ovf_cnt(ovf_cnt)
  );

  always #5 clk_20 = ~clk_20;

  task automatic chk(input string nm, input logic [80:0] act, input logic [80:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] main;
    logic [15:0] omega;
    logic [15:0] omni;
    logic [15:0] thr;
    logic [15:0] mrg;
    logic [8:0]  brg;
    logic [23:0] ts;
  } smp_t;

  smp_t        s0 = '0;
  smp_t        run_q[$];
  logic [80:0] mq[$];
  logic [80:0] pend = '0;
  logic [80:0] m_head = '0;
  bit          pend_vld = 1'b0;
  int          m_ovf = 0;
  logic [23:0] ecnt = '0;

  function automatic bit is_hit(input smp_t s);
    return (s.main >= s.thr) && ({1'b0, s.main} >= {1'b0, s.omega} + {1'b0, s.mrg});
  endfunction

  function automatic logic [80:0] make_report();
    int best = 0;
    for (int i = 1; i < run_q.size(); i++)
      if (run_q[i].main > run_q[best].main) best = i;
    return {run_q[0].ts, 8'(run_q.size()), run_q[best].main, run_q[best].omni, run_q[best].brg, 8'h00};
  endfunction

  initial begin : model
    smp_t cur;
    bit   pop;
    forever begin
      @(posedge clk_20 or posedge reset);
      if (reset) begin
        s0 = '0; run_q.delete(); mq.delete(); pend_vld = 1'b0; pend = '0;
        m_head = '0; m_ovf = 0; ecnt = '0;
      end else begin
        cur = s0;
        pop = (mq.size() != 0) && rpt_ready;
        if (pop) void'(mq.pop_front());
        if (pend_vld) begin
          if (mq.size() < FIFO_DEPTH) mq.push_back(pend);
          else if (m_ovf < 255) m_ovf++;
        end
        if (mq.size() != 0) m_head = mq[0];
        pend_vld = 1'b0;
        if (!enable) run_q.delete();
        else if (is_hit(cur)) run_q.push_back(cur);
        else begin
          if (run_q.size() >= MIN_W && run_q.size() <= MAX_W) begin
            pend = make_report();
            pend_vld = 1'b1;
          end
          run_q.delete();
        end
        s0.main = ampl_main; s0.omega = ampl_omega; s0.omni = ampl_omni;
        s0.thr = thr; s0.mrg = sls_margin; s0.brg = bearing; s0.ts = ecnt;
        ecnt = ecnt + 24'd1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk_20);
      if (chk_en && !reset) begin
        chk("cyc_valid", 81'(rpt_valid), 81'(mq.size() != 0));
        chk("cyc_data", rpt_data, m_head);
        chk("cyc_ovf", 81'(ovf_cnt), 81'(m_ovf[7:0]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [80:0] ft0(input logic [80:0] r);  return 81'(r[80:57]); endfunction
  function automatic logic [80:0] fw(input logic [80:0] r);   return 81'(r[56:49]); endfunction
  function automatic logic [80:0] fpk(input logic [80:0] r);  return 81'(r[48:33]); endfunction
  function automatic logic [80:0] fbrg(input logic [80:0] r); return 81'(r[16:8]);  endfunction

  task automatic drv(input logic [15:0] m, input logic [15:0] om, input logic [8:0] b);
    ampl_main = m; ampl_omega = om; ampl_omni = 16'($urandom); bearing = b;
    @(negedge clk_20);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drv(16'd0, 16'd0, 9'd0);
  endtask

  task automatic pulse(input int w, input logic [15:0] lvl, input logic [8:0] b);
    for (int i = 0; i < w; i++) drv(lvl, 16'd0, b);
  endtask

  task automatic pop_one();
    rpt_ready = 1'b1;
    quiet(1);
    rpt_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d so far", n_pass, n_tot);
    $fatal(1, "timeout");
  end

  logic [23:0] t_first;

  initial begin : stim
    reset = 1'b1; enable = 1'b0; rpt_ready = 1'b0;
    thr = 16'd1000; sls_margin = 16'd100;
    ampl_main = '0; ampl_omega = '0; ampl_omni = '0; bearing = '0;
    #1;
    chk("rst_valid", 81'(rpt_valid), 81'(0));
    chk("rst_data", rpt_data, 81'(0));
    chk("rst_ovf", 81'(ovf_cnt), 81'(0));
    @(negedge clk_20); @(negedge clk_20);
    reset = 1'b0; chk_en = 1'b1;
    quiet(2);
    enable = 1'b1;
    quiet(3);

    // 1: basic pulse, peak mid-pulse, exact latency
    t_first = ecnt;
    for (int i = 1; i <= 9; i++)
      drv((i == 4) ? 16'd3000 : 16'd2000, 16'd0, (i == 4) ? 9'd123 : 9'd45);
    quiet(2);
    chk("t1_lat_early", 81'(rpt_valid), 81'(0));
    quiet(1);
    chk("t1_lat_valid", 81'(rpt_valid), 81'(1));
    chk("t1_width", fw(rpt_data), 81'(9));
    chk("t1_peak", fpk(rpt_data), 81'(3000));
    chk("t1_brg", fbrg(rpt_data), 81'(123));
    chk("t1_t0", ft0(rpt_data), 81'(t_first));
    pop_one();
    quiet(1);
    chk("t1_single", 81'(rpt_valid), 81'(0));

    // 2: sidelobe margin fails
    for (int i = 1; i <= 9; i++)
      drv((i == 4) ? 16'd3000 : 16'd2000, 16'd1950, 9'd45);
    quiet(6);
    chk("t2_noreport", 81'(rpt_valid), 81'(0));
    chk("t2_ovf", 81'(ovf_cnt), 81'(0));

    // 3: width limits and recovery after TOOLONG
    pulse(5, 16'd2000, 9'd1);  quiet(3);
    pulse(6, 16'd2000, 9'd2);  quiet(3);
    pulse(30, 16'd2000, 9'd3); quiet(3);
    pulse(31, 16'd2000, 9'd4); quiet(3);
    pulse(40, 16'd2000, 9'd5); quiet(1);
    pulse(8, 16'd2000, 9'd6);  quiet(6);
    chk("t3_v0", 81'(rpt_valid), 81'(1));
    chk("t3_w6", fw(rpt_data), 81'(6));
    pop_one();
    chk("t3_v1", 81'(rpt_valid), 81'(1));
    chk("t3_w30", fw(rpt_data), 81'(30));
    pop_one();
    chk("t3_v2", 81'(rpt_valid), 81'(1));
    chk("t3_w8", fw(rpt_data), 81'(8));
    pop_one();
    chk("t3_empty", 81'(rpt_valid), 81'(0));

    // 4: overflow with consumer stalled, then in-order drain
    for (int i = 0; i < 6; i++) begin
      pulse(6, 16'(1100 + 100*i), 9'(i));
      quiet(2);
    end
    quiet(4);
    chk("t4_ovf", 81'(ovf_cnt), 81'(2));
    rpt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_v", 81'(rpt_valid), 81'(1));
      chk("t4_drain_pk", fpk(rpt_data), 81'(1100 + 100*i));
      quiet(1);
    end
    rpt_ready = 1'b0;
    chk("t4_empty", 81'(rpt_valid), 81'(0));

    // 5: back-to-back pulses, tied peaks keep the earliest bearing
    for (int i = 1; i <= 8; i++)
      drv((i == 2 || i == 5) ? 16'd2500 : 16'd2000, 16'd0, 9'(i*10));
    quiet(1);
    pulse(8, 16'd2200, 9'd99);
    quiet(5);
    chk("t5_v0", 81'(rpt_valid), 81'(1));
    chk("t5_w0", fw(rpt_data), 81'(8));
    chk("t5_pk0", fpk(rpt_data), 81'(2500));
    chk("t5_brg0", fbrg(rpt_data), 81'(20));
    pop_one();
    chk("t5_v1", 81'(rpt_valid), 81'(1));
    chk("t5_w1", fw(rpt_data), 81'(8));
    chk("t5_brg1", fbrg(rpt_data), 81'(99));
    pop_one();
    chk("t5_empty", 81'(rpt_valid), 81'(0));

    // 6: enable drop mid-pulse, then asynchronous reset with queued reports
    pulse(7, 16'd2000, 9'd1);
    enable = 1'b0;
    drv(16'd2000, 16'd0, 9'd1);
    quiet(2);
    enable = 1'b1;
    quiet(5);
    chk("t6_en_drop", 81'(rpt_valid), 81'(0));
    pulse(6, 16'd2100, 9'd3); quiet(1);
    pulse(6, 16'd2200, 9'd4); quiet(5);
    chk("t6_queued", 81'(rpt_valid), 81'(1));
    pulse(3, 16'd2300, 9'd5);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 81'(rpt_valid), 81'(0));
    chk("t6_rst_data", rpt_data, 81'(0));
    chk("t6_rst_ovf", 81'(ovf_cnt), 81'(0));
    @(negedge clk_20); @(negedge clk_20);
    reset = 1'b0;
    quiet(3);
    pulse(7, 16'd2000, 9'd7);
    quiet(3);
    chk("t6_post_v", 81'(rpt_valid), 81'(1));
    chk("t6_post_t0", ft0(rpt_data), 81'(3));
    chk("t6_post_w", fw(rpt_data), 81'(7));
    pop_one();

    // 7: overflow counter saturates
    for (int i = 0; i < 262; i++) begin
      pulse(6, 16'd1500, 9'd0);
      quiet(1);
    end
    quiet(4);
    chk("t7_ovf_sat", 81'(ovf_cnt), 81'(255));
    rpt_ready = 1'b1;
    quiet(6);
    rpt_ready = 1'b0;

    // randomized traffic
    for (int s = 0; s < 150; s++) begin
      int w;
      int g;
      w = $urandom_range(1, 40);
      g = $urandom_range(1, 3);
      for (int i = 0; i < w + g; i++) begin
        rpt_ready = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 59) != 0);
        if (i < w)
          drv(($urandom_range(0, 29) == 0) ? 16'd900 : 16'($urandom_range(1000, 4000)),
              ($urandom_range(0, 24) == 0) ? 16'd3950 : 16'($urandom_range(0, 800)),
              9'($urandom_range(0, 359)));
        else
          quiet(1);
      end
    end
    enable = 1'b1;
    rpt_ready = 1'b1;
    quiet(10);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
